compound_stream_arbiter: RTL and testbench
==========================================

Name: compound_stream_arbiter

Overview:
- Shares one CompoundType output channel between NUM_REQ producers.
- Each producer drives a CompoundType stream over the existing blocking sync/notify port protocol.
- The arbiter grants one producer per transaction (round-robin), reads one value, and forwards it unchanged to the single consumer.
- Sits in front of TestBasic16-style consumers whose b_in port would otherwise be point-to-point.

Parameters:
- NUM_REQ, 2, number of requesting producers; legal range 2..8.
- GW, $clog2(NUM_REQ), width of the grant index; derived, not overridden.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- req_in  input  NUM_REQ x CompoundType  producer data.
- req_in_sync  input  NUM_REQ  producer has valid data; held high until read.
- req_in_notify  output  NUM_REQ  arbiter reads this producer this cycle (one-hot or zero).
- arb_out  output  CompoundType  forwarded value.
- arb_out_sync  input  1  consumer accepts arb_out.
- arb_out_notify  output  1  arb_out valid.
- grant_id  output  GW  index of the current or last granted producer.
- busy  output  1  high outside section_idle.

Behaviour:
Reset values (rst high at posedge):
- phase = section_idle; all req_in_notify = 0; arb_out_notify = 0; arb_out = all fields 0.
- grant_id = 0; last-grant pointer = NUM_REQ-1, so producer 0 wins first; busy = 0.
- Reset mid-transaction discards any held value. No output pulse occurs after reset.

Transfer definitions:
- Input transfer: req_in_sync[i] && req_in_notify[i] at a posedge.
- Output transfer: arb_out_sync && arb_out_notify at a posedge.
- All outputs are registered.

FSM (ArbPhases):
- section_idle:
  - Notifies low.
  - If any req_in_sync is high, select the winner W = first set bit searching from last+1, wrapping modulo NUM_REQ.
  - Register grant_id = W, set req_in_notify[W] = 1, go to section_read.
  - If no sync is high, stay.
- section_read:
  - req_in_notify[W] is high for exactly this cycle.
  - If req_in_sync[W] is high: capture req_in[W] into arb_out, set last = W, clear notify, set arb_out_notify = 1, go to section_write.
  - If req_in_sync[W] has dropped (producer protocol violation): clear notify, leave last unchanged, return to section_idle. No output occurs.
- section_write:
  - arb_out is held stable while arb_out_notify is high.
  - On arb_out_sync: clear arb_out_notify, go to section_idle.
  - Otherwise wait indefinitely.

Latency and throughput:
- Minimum latency from sync at posedge k: notify visible after k, data captured at k+1, arb_out_notify visible after k+1.
- One transaction per 3 cycles when the consumer accepts immediately.

Boundary conditions:
- Requests arriving during section_read or section_write are ignored until section_idle.
- Simultaneous requests are resolved only by the rotation.
- With all producers requesting continuously, grants cycle 0,1,..,NUM_REQ-1,0.
- A producer is never granted twice in a row while another requests.
- At most one req_in_notify bit is ever high.
- arb_out_notify and any req_in_notify are never high in the same cycle.
- The last pointer wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro: COMPOUND_ARB_FIXED_PRIO_EN.
- Defined: the winner is the lowest-index producer with sync high, and the last pointer is unused.
- Defined, starvation: producer 0 may starve others; this is intended for the debug/priority builds.
- Undefined: round-robin exactly as described above.
- Either way: port list and FSM timing are identical.

Decomposition:
- Package compound_arb_types holds:
  - typedef enum ArbPhases {section_idle, section_read, section_write};
  - constant ARB_MAX_REQ = 8.
- CompoundType stays in top_level_types and is imported, not redefined.
- One sub-module, compound_rr_pick: combinational.
  - Inputs: request vector, last pointer.
  - Outputs: winner index, any-request flag.
  - Fixed-priority selection under the macro lives here.

Test Plan:
- Reset then idle:
  - Stimulus: rst high 2 cycles, then all syncs low for 10 cycles.
  - Required: every notify 0, arb_out.x = 0, busy = 0, grant_id = 0.
- Single request:
  - Stimulus: producer 1 holds sync with x = 5; consumer arb_out_sync tied high.
  - Required: req_in_notify = 2'b10 one cycle later; arb_out_notify with arb_out.x = 5 the following cycle; grant_id = 1.
- Contention, round-robin:
  - Stimulus: NUM_REQ = 4, all producers sync continuously with x = 10+i.
  - Required: outputs x = 10, 11, 12, 13, 10, in that order.
- Consumer backpressure:
  - Stimulus: arb_out_sync held low 6 cycles after arb_out_notify rises.
  - Required: arb_out stable, no req_in_notify pulses, busy = 1; completes the cycle sync rises.
- Abort and reset mid-operation:
  - Abort stimulus: producer 0 drops sync in section_read.
  - Abort required: no output; next grant is still producer 0.
  - Reset stimulus: rst asserted during section_write.
  - Reset required: arb_out_notify = 0 next cycle and state is idle.
- Fixed priority (with COMPOUND_ARB_FIXED_PRIO_EN):
  - Stimulus: producers 0 and 2 sync continuously.
  - Required: only producer 0 is granted.

Source files
------------

// File: rtl/compound_stream_arbiter_pkg.sv
// Shared type definitions for the compound stream arbiter slice.
//
// top_level_types    : CompoundType, the record carried on every producer
//                      stream and on the consumer channel.
// compound_arb_types : ArbPhases (arbiter FSM phases) and ARB_MAX_REQ, the
//                      largest supported number of producers.
//
// No ports; packages only.

package top_level_types;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } CompoundType;

endpackage

package compound_arb_types;

  typedef enum logic [1:0] {
    section_idle,
    section_read,
    section_write
  } ArbPhases;

  localparam int ARB_MAX_REQ = 8;

endpackage

// File: rtl/compound_stream_arbiter_if.sv
// Bundle of the producer-side and consumer-side stream signals of the
// compound stream arbiter.
//
// Handshake: a transfer happens at a posedge where both the "sync" and the
// "notify" of a port are high. Producers hold req_in_sync (and req_in)
// until their notify is seen; the arbiter holds arb_out stable while
// arb_out_notify is high until arb_out_sync is seen.
//
// Signals:
//   req_in[NUM_REQ]  producer data
//   req_in_sync      producer has valid data
//   req_in_notify    arbiter reads this producer this cycle (one-hot or zero)
//   arb_out          forwarded value
//   arb_out_sync     consumer accepts arb_out
//   arb_out_notify   arb_out valid
//   grant_id         current or last granted producer
//   busy             arbiter is outside section_idle
//   phase            FSM phase, exported for observation
// Modports: master = arbiter side, slave = producers/consumer side.

interface compound_stream_arbiter_if
  import top_level_types::*;
  import compound_arb_types::*;
#(
  parameter int NUM_REQ = 2
);
  localparam int GW = $clog2(NUM_REQ);

  CompoundType        req_in [NUM_REQ];
  logic [NUM_REQ-1:0] req_in_sync;
  logic [NUM_REQ-1:0] req_in_notify;
  CompoundType        arb_out;
  logic               arb_out_sync;
  logic               arb_out_notify;
  logic [GW-1:0]      grant_id;
  logic               busy;
  ArbPhases           phase;

  modport master (
    input  req_in, req_in_sync, arb_out_sync,
    output req_in_notify, arb_out, arb_out_notify, grant_id, busy, phase
  );

  modport slave (
    output req_in, req_in_sync, arb_out_sync,
    input  req_in_notify, arb_out, arb_out_notify, grant_id, busy, phase
  );

endinterface

// File: rtl/compound_stream_arbiter_rr_pick.sv
// compound_rr_pick: combinational winner selection for the arbiter.
//
// Build option: COMPOUND_ARB_FIXED_PRIO_EN
//   undefined - round-robin: first requester searching from last+1,
//               wrapping modulo NUM_REQ.
//   defined   - fixed priority: lowest-index requester wins; last ignored.
//
// Ports:
//   req      in   NUM_REQ  request vector (producer syncs)
//   last     in   GW       previously granted producer
//   winner   out  GW       selected producer (0 when no request)
//   any_req  out  1        at least one request present

module compound_rr_pick
  import compound_arb_types::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any_req
);
  localparam int GW = $clog2(NUM_REQ);

  assign any_req = |req;

`ifdef COMPOUND_ARB_FIXED_PRIO_EN
  logic          unused_last;
  logic [GW-1:0] cand;

  assign unused_last = ^last;

  // Walk downward so the lowest set index is the last one written.
  always_comb begin
    winner = '0;
    cand   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = GW'(i);
      if (req[cand]) winner = cand;
    end
  end
`else
  logic [GW-1:0] cand;
  int            idx;

  // Walk the search order backwards (offset NUM_REQ down to 1) so the
  // requester closest after "last" is the final one written.
  always_comb begin
    winner = '0;
    cand   = '0;
    idx    = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx  = (int'(last) + k) % NUM_REQ;
      cand = GW'(idx);
      if (req[cand]) winner = cand;
    end
  end
`endif

endmodule

// File: rtl/compound_stream_arbiter.sv
// compound_stream_arbiter: shares one CompoundType consumer channel between
// NUM_REQ producers. One producer is granted per transaction, one value is
// read from it and forwarded unchanged. Every output is a register (busy
// and phase are taken straight from the state register).
//
// Build option: COMPOUND_ARB_FIXED_PRIO_EN selects fixed priority instead
// of round-robin (see compound_rr_pick); ports and timing are unchanged.
//
// Ports:
//   clk  in   clock, posedge
//   rst  in   synchronous active-high reset
//   bus  compound_stream_arbiter_if.master (producer and consumer streams,
//        grant_id, busy, phase)
//
// Parameters: NUM_REQ (2..ARB_MAX_REQ), must match the interface instance.

module compound_stream_arbiter
  import top_level_types::*;
  import compound_arb_types::*;
#(
  parameter int NUM_REQ = 2
) (
  input logic                       clk,
  input logic                       rst,
  compound_stream_arbiter_if.master bus
);
  localparam int GW = $clog2(NUM_REQ);

  ArbPhases           state_q, state_n;
  logic [NUM_REQ-1:0] notify_q, notify_n;
  CompoundType        out_q, out_n;
  logic               out_valid_q, out_valid_n;
  logic [GW-1:0]      grant_q, grant_n;
  logic [GW-1:0]      last_q, last_n;
  logic [GW-1:0]      pick_idx;
  logic               pick_any;

  compound_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (bus.req_in_sync),
    .last    (last_q),
    .winner  (pick_idx),
    .any_req (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= section_idle;
      notify_q    <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      grant_q     <= '0;
      // Pointer starts at the top index so producer 0 wins first.
      last_q      <= GW'(NUM_REQ - 1);
    end else begin
      state_q     <= state_n;
      notify_q    <= notify_n;
      out_q       <= out_n;
      out_valid_q <= out_valid_n;
      grant_q     <= grant_n;
      last_q      <= last_n;
    end
  end

  // Notify is a one-cycle pulse: it defaults low and is only raised on the
  // idle->read transition, so it is high during section_read alone.
  always_comb begin
    state_n     = state_q;
    notify_n    = '0;
    out_n       = out_q;
    out_valid_n = out_valid_q;
    grant_n     = grant_q;
    last_n      = last_q;
    unique case (state_q)
      section_idle: begin
        out_valid_n = 1'b0;
        if (pick_any) begin
          grant_n            = pick_idx;
          notify_n[pick_idx] = 1'b1;
          state_n            = section_read;
        end
      end
      section_read: begin
        if (bus.req_in_sync[grant_q]) begin
          out_n       = bus.req_in[grant_q];
          last_n      = grant_q;
          out_valid_n = 1'b1;
          state_n     = section_write;
        end else begin
          // Producer withdrew: drop the grant without moving the pointer.
          state_n = section_idle;
        end
      end
      section_write: begin
        if (bus.arb_out_sync) begin
          out_valid_n = 1'b0;
          state_n     = section_idle;
        end
      end
      default: state_n = section_idle;
    endcase
  end

  assign bus.req_in_notify  = notify_q;
  assign bus.arb_out        = out_q;
  assign bus.arb_out_notify = out_valid_q;
  assign bus.grant_id       = grant_q;
  assign bus.busy           = (state_q != section_idle);
  assign bus.phase          = state_q;

endmodule

// File: tb/tb_compound_stream_arbiter.sv
// Testbench for compound_stream_arbiter with NUM_REQ = 4.
// Directed steps in one initial block; forwarded values are predicted and
// queued as {grant_id, CompoundType} when stimulus is set up, and popped on
// each consumer-side transfer. Protocol invariants are checked every cycle.

module tb_compound_stream_arbiter;
  import top_level_types::*;
  import compound_arb_types::*;

  localparam int NUM_REQ = 4;
  localparam int GW      = $clog2(NUM_REQ);
  localparam int W       = GW + $bits(CompoundType);

  logic clk;
  logic rst;

  compound_stream_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  compound_stream_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  logic [W-1:0] exp_q[$];
  int nvec;
  int nerr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic CompoundType mk(input int x);
    CompoundType c;
    c.x = 16'(x);
    c.y = 16'(x * 3 + 1);
    return c;
  endfunction

  // Driver: inputs are already set; check what the coming edge does and
  // the invariants of the current cycle, then advance to just after it.
  task automatic tick();
    logic [W-1:0] e;
    if (bus.arb_out_notify && bus.arb_out_sync) begin
      check("scoreboard_has_entry", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_data", 64'({bus.grant_id, bus.arb_out}), 64'(e));
      end
    end
    check("notify_onehot0", 64'($onehot0(bus.req_in_notify)), 64'd1);
    check("notify_exclusive", 64'(bus.arb_out_notify && (|bus.req_in_notify)), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst  = 1'b1;
    bus.req_in_sync  = '0;
    bus.arb_out_sync = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) bus.req_in[i] = '0;
    @(posedge clk);
    #1;

    // Reset then idle
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_notify", 64'(bus.req_in_notify), 64'd0);
      check("idle_out_notify", 64'(bus.arb_out_notify), 64'd0);
      check("idle_x", 64'(bus.arb_out.x), 64'd0);
      check("idle_busy", 64'(bus.busy), 64'd0);
      check("idle_grant", 64'(bus.grant_id), 64'd0);
    end
    check("idle_phase", 64'(bus.phase), 64'(section_idle));

    // Single request from producer 1, consumer always ready
    bus.arb_out_sync   = 1'b1;
    bus.req_in[1]      = mk(5);
    bus.req_in_sync[1] = 1'b1;
    exp_q.push_back({GW'(1), mk(5)});
    tick();
    check("single_notify", 64'(bus.req_in_notify), 64'b0010);
    check("single_grant", 64'(bus.grant_id), 64'd1);
    check("single_phase_read", 64'(bus.phase), 64'(section_read));
    check("single_busy", 64'(bus.busy), 64'd1);
    check("single_no_out_yet", 64'(bus.arb_out_notify), 64'd0);
    tick();
    bus.req_in_sync[1] = 1'b0;
    check("single_out_notify", 64'(bus.arb_out_notify), 64'd1);
    check("single_x", 64'(bus.arb_out.x), 64'd5);
    check("single_grant_hold", 64'(bus.grant_id), 64'd1);
    check("single_notify_clear", 64'(bus.req_in_notify), 64'd0);
    tick();
    check("single_done", 64'(bus.arb_out_notify), 64'd0);
    check("single_phase_idle", 64'(bus.phase), 64'(section_idle));
    check("single_queue_empty", 64'(exp_q.size()), 64'd0);

    // Contention: all four producers request continuously
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) bus.req_in[i] = mk(10 + i);
    bus.req_in_sync = '1;
`ifdef COMPOUND_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 5; i++) exp_q.push_back({GW'(0), mk(10)});
`else
    exp_q.push_back({GW'(0), mk(10)});
    exp_q.push_back({GW'(1), mk(11)});
    exp_q.push_back({GW'(2), mk(12)});
    exp_q.push_back({GW'(3), mk(13)});
    exp_q.push_back({GW'(0), mk(10)});
`endif
    repeat (15) tick();
    bus.req_in_sync = '0;
    check("rr_queue_empty", 64'(exp_q.size()), 64'd0);
    check("rr_phase_idle", 64'(bus.phase), 64'(section_idle));

`ifndef COMPOUND_ARB_FIXED_PRIO_EN
    // Backpressure: producer 2 granted (pointer now at 0), consumer stalls
    bus.arb_out_sync   = 1'b0;
    bus.req_in[2]      = mk(77);
    bus.req_in_sync[2] = 1'b1;
    exp_q.push_back({GW'(2), mk(77)});
    tick();
    check("bp_notify", 64'(bus.req_in_notify), 64'b0100);
    check("bp_grant", 64'(bus.grant_id), 64'd2);
    tick();
    bus.req_in_sync[2] = 1'b0;
    // Late requests must be ignored until the arbiter is idle again
    bus.req_in[0]      = mk(44);
    bus.req_in[3]      = mk(33);
    bus.req_in_sync[0] = 1'b1;
    bus.req_in_sync[3] = 1'b1;
    check("bp_out_rise", 64'(bus.arb_out_notify), 64'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("bp_hold_notify", 64'(bus.arb_out_notify), 64'd1);
      check("bp_hold_data", 64'(bus.arb_out), 64'(mk(77)));
      check("bp_no_req_notify", 64'(bus.req_in_notify), 64'd0);
      check("bp_busy", 64'(bus.busy), 64'd1);
    end
    bus.arb_out_sync = 1'b1;
    exp_q.push_back({GW'(3), mk(33)});
    tick();
    check("bp_release", 64'(bus.arb_out_notify), 64'd0);
    check("bp_release_idle", 64'(bus.phase), 64'(section_idle));
    tick();
    check("bp_next_grant", 64'(bus.grant_id), 64'd3);
    check("bp_next_notify", 64'(bus.req_in_notify), 64'b1000);
    tick();
    bus.req_in_sync[3] = 1'b0;
    check("bp_next_x", 64'(bus.arb_out.x), 64'd33);
    tick();

    // Abort: producer 0 granted (pointer wraps 3 -> 0), then withdraws
    tick();
    check("abort_grant", 64'(bus.grant_id), 64'd0);
    check("abort_notify", 64'(bus.req_in_notify), 64'b0001);
    bus.req_in_sync[0] = 1'b0;
    tick();
    check("abort_idle", 64'(bus.phase), 64'(section_idle));
    check("abort_no_out", 64'(bus.arb_out_notify), 64'd0);
    check("abort_notify_clear", 64'(bus.req_in_notify), 64'd0);
    // Pointer unchanged at 3, so producer 0 beats producer 1 again
    bus.req_in[1]      = mk(55);
    bus.req_in_sync[0] = 1'b1;
    bus.req_in_sync[1] = 1'b1;
    tick();
    check("abort_regrant", 64'(bus.grant_id), 64'd0);
    check("abort_regrant_notify", 64'(bus.req_in_notify), 64'b0001);

    // Reset during section_write discards the held value
    bus.arb_out_sync = 1'b0;
    tick();
    bus.req_in_sync = '0;
    check("rst_write_notify", 64'(bus.arb_out_notify), 64'd1);
    check("rst_write_x", 64'(bus.arb_out.x), 64'd44);
    check("rst_write_phase", 64'(bus.phase), 64'(section_write));
    tick();
    rst = 1'b1;
    tick();
    check("rst_out_notify", 64'(bus.arb_out_notify), 64'd0);
    check("rst_phase", 64'(bus.phase), 64'(section_idle));
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_grant", 64'(bus.grant_id), 64'd0);
    check("rst_x", 64'(bus.arb_out.x), 64'd0);
    rst = 1'b0;
    bus.arb_out_sync = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst_no_pulse", 64'(bus.arb_out_notify), 64'd0);
    end
    check("rst_queue_empty", 64'(exp_q.size()), 64'd0);
`endif

    // Producers 0 and 2 request continuously after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.arb_out_sync = 1'b1;
    bus.req_in[0]    = mk(44);
    bus.req_in[2]    = mk(77);
    bus.req_in_sync  = 4'b0101;
`ifdef COMPOUND_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) exp_q.push_back({GW'(0), mk(44)});
`else
    exp_q.push_back({GW'(0), mk(44)});
    exp_q.push_back({GW'(2), mk(77)});
    exp_q.push_back({GW'(0), mk(44)});
`endif
    repeat (9) tick();
    bus.req_in_sync = '0;
    check("prio_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
